// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and helpers.
// Patterns are active-low a..g, index 0 = segment a.
package seg7_pkg;

   typedef logic [0:6] seg7_t;

   localparam seg7_t SEG7_0     = 7'b0000001;
   localparam seg7_t SEG7_1     = 7'b1001111;
   localparam seg7_t SEG7_2     = 7'b0010010;
   localparam seg7_t SEG7_3     = 7'b0000110;
   localparam seg7_t SEG7_4     = 7'b1001100;
   localparam seg7_t SEG7_5     = 7'b0100100;
   localparam seg7_t SEG7_6     = 7'b0100000;
   localparam seg7_t SEG7_7     = 7'b0001111;
   localparam seg7_t SEG7_8     = 7'b0000000;
   localparam seg7_t SEG7_9     = 7'b0000100;
   localparam seg7_t SEG7_BLANK = 7'b1111111;

   localparam logic [3:0] CODE_BLANK = 4'hF;
   localparam logic [3:0] CODE_ERR   = 4'hE;

   // True when exactly one of the four digit selects is active.
   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to BCD decoder.
// Exact match only; anything unrecognised is flagged as an error.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [0:6] seg_i,
   output logic [3:0] code_o,
   output logic       blank_o,
   output logic       err_o
);

   // Map the active-low pattern back to its digit code and flags.
   always_comb begin
      code_o  = CODE_ERR;
      blank_o = 1'b0;
      err_o   = 1'b0;
      case (seg_i)
         SEG7_0:     code_o = 4'd0;
         SEG7_1:     code_o = 4'd1;
         SEG7_2:     code_o = 4'd2;
         SEG7_3:     code_o = 4'd3;
         SEG7_4:     code_o = 4'd4;
         SEG7_5:     code_o = 4'd5;
         SEG7_6:     code_o = 4'd6;
         SEG7_7:     code_o = 4'd7;
         SEG7_8:     code_o = 4'd8;
         SEG7_9:     code_o = 4'd9;
         SEG7_BLANK: begin
            code_o  = CODE_BLANK;
            blank_o = 1'b1;
         end
         default: begin
            code_o = CODE_ERR;
            err_o  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/seg7_readback_capture.sv
// Reads back a multiplexed 4-digit active-low segment bus.
// Each digit is latched once its pattern has been stable long enough.
module seg7_readback_capture
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic        CLOCK_50,
   input  logic        RESET_N,
   input  logic [0:6]  SEG_IN,
   input  logic [3:0]  DIG_SEL,
   output logic [15:0] DIGITS,
   output logic [3:0]  BLANK,
   output logic [3:0]  ERR,
   output logic        SEL_ERR,
   output logic        UPDATE
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   // Input sample and its previous-cycle copy for change detect.
   logic [0:6]       seg_q;
   logic [3:0]       sel_q;
   logic [0:6]       seg_prev_q;
   logic [3:0]       sel_prev_q;

   // Stability tracking.
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             captured_q, captured_d;

   // Latched slot state.
   logic [15:0]      digits_q, digits_d;
   logic [3:0]       blank_q, blank_d;
   logic [3:0]       err_q, err_d;

   // Output pulses.
   logic             update_q, update_d;
   logic             sel_err_q, sel_err_d;

   // Decoder and control signals.
   logic [3:0]       dec_code;
   logic             dec_blank;
   logic             dec_err;
   logic             change;
   logic             capture;
   logic             sel_ok;
   logic             slot_diff;

   seg7_decode u_decode (
      .seg_i   (seg_q),
      .code_o  (dec_code),
      .blank_o (dec_blank),
      .err_o   (dec_err)
   );

   // Detect a changed sample and qualify a capture on this edge.
   always_comb begin
      change  = (seg_q != seg_prev_q) || (sel_q != sel_prev_q);
      sel_ok  = is_onehot4(sel_q);
      capture = !change && (cnt_q == CNT_MAX) && !captured_q;
   end

   // Stability counter saturates; a change restarts the run.
   always_comb begin
      cnt_d      = cnt_q;
      captured_d = captured_q;
      if (change) begin
         cnt_d      = '0;
         captured_d = 1'b0;
      end else begin
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (capture) begin
            captured_d = 1'b1;
         end
      end
   end

   // Write the selected slot and note whether anything changed.
   always_comb begin
      digits_d  = digits_q;
      blank_d   = blank_q;
      err_d     = err_q;
      slot_diff = 1'b0;
      if (capture && sel_ok) begin
         for (int k = 0; k < 4; k++) begin
            if (sel_q[k]) begin
               if ((digits_q[4*k +: 4] != dec_code) ||
                   (blank_q[k] != dec_blank) ||
                   (err_q[k] != dec_err)) begin
                  slot_diff = 1'b1;
               end
               digits_d[4*k +: 4] = dec_code;
               blank_d[k]         = dec_blank;
               err_d[k]           = dec_err;
            end
         end
      end
   end

   // Pulses fire the cycle after the capture edge.
   always_comb begin
      update_d  = capture && sel_ok && slot_diff;
      sel_err_d = capture && !sel_ok;
   end

   // Register the raw pins once and keep the prior sample.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         seg_q      <= SEG7_BLANK;
         sel_q      <= 4'd0;
         seg_prev_q <= SEG7_BLANK;
         sel_prev_q <= 4'd0;
      end else begin
         seg_q      <= SEG_IN;
         sel_q      <= DIG_SEL;
         seg_prev_q <= seg_q;
         sel_prev_q <= sel_q;
      end
   end

   // Stability counter and one-capture-per-run flag.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q      <= '0;
         captured_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         captured_q <= captured_d;
      end
   end

   // Slot registers.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         digits_q <= 16'hFFFF;
         blank_q  <= 4'b1111;
         err_q    <= 4'b0000;
      end else begin
         digits_q <= digits_d;
         blank_q  <= blank_d;
         err_q    <= err_d;
      end
   end

   // Single-cycle status pulses.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         update_q  <= 1'b0;
         sel_err_q <= 1'b0;
      end else begin
         update_q  <= update_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign DIGITS  = digits_q;
   assign BLANK   = blank_q;
   assign ERR     = err_q;
   assign UPDATE  = update_q;
   assign SEL_ERR = sel_err_q;

endmodule

// File: tb/tb_seg7_readback_capture.sv
// Scoreboard bench for seg7_readback_capture.
// Directed vectors; pulses are matched against queued expectations.
module tb_seg7_readback_capture;

   logic        CLOCK_50;
   logic        RESET_N;
   logic [0:6]  SEG_IN;
   logic [3:0]  DIG_SEL;
   logic [15:0] DIGITS;
   logic [3:0]  BLANK;
   logic [3:0]  ERR;
   logic        SEL_ERR;
   logic        UPDATE;

   seg7_readback_capture #(
      .STABLE_CYCLES (4),
      .CNT_W         (8)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .SEG_IN   (SEG_IN),
      .DIG_SEL  (DIG_SEL),
      .DIGITS   (DIGITS),
      .BLANK    (BLANK),
      .ERR      (ERR),
      .SEL_ERR  (SEL_ERR),
      .UPDATE   (UPDATE)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      logic [1:0]  kind;
      logic [15:0] d;
      logic [3:0]  b;
      logic [3:0]  e;
   } exp_t;

   localparam logic [1:0] K_UPD = 2'b10;
   localparam logic [1:0] K_SEL = 2'b01;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] k, input logic [15:0] d,
                       input logic [3:0] b, input logic [3:0] e);
      exp_t x;
      x.kind = k;
      x.d    = d;
      x.b    = b;
      x.e    = e;
      sbq.push_back(x);
   endtask

   // Hold one pin pattern for n sampled edges.
   task automatic apply(input logic [0:6] s, input logic [3:0] sel,
                        input int n);
      @(negedge CLOCK_50);
      SEG_IN  = s;
      DIG_SEL = sel;
      repeat (n - 1) @(negedge CLOCK_50);
   endtask

   // Monitor: every pulse must match the oldest expectation.
   always @(negedge CLOCK_50) begin
      if (RESET_N && (UPDATE || SEL_ERR)) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got upd=%0b sel=%0b want none",
                     UPDATE, SEL_ERR);
         end else begin
            exp_t x;
            x = sbq.pop_front();
            chk("pulse_kind", {30'd0, UPDATE, SEL_ERR}, {30'd0, x.kind});
            chk("sb_digits", {16'd0, DIGITS}, {16'd0, x.d});
            chk("sb_blank", {28'd0, BLANK}, {28'd0, x.b});
            chk("sb_err", {28'd0, ERR}, {28'd0, x.e});
         end
      end
   end

   initial begin
      RESET_N = 1'b0;
      SEG_IN  = 7'b1111111;
      DIG_SEL = 4'b0001;
      repeat (3) @(negedge CLOCK_50);
      RESET_N = 1'b1;
      #1;
      chk("rst_digits", {16'd0, DIGITS}, 32'hFFFF);
      chk("rst_blank", {28'd0, BLANK}, 32'hF);
      chk("rst_err", {28'd0, ERR}, 32'h0);
      chk("rst_pulses", {30'd0, UPDATE, SEL_ERR}, 32'h0);
      repeat (8) @(negedge CLOCK_50);
      chk("idle_digits", {16'd0, DIGITS}, 32'hFFFF);

      // Digit 2 into slot 2, check exact latch edge.
      push(K_UPD, 16'hF2FF, 4'b1011, 4'b0000);
      SEG_IN  = 7'b0010010;
      DIG_SEL = 4'b0100;
      repeat (5) @(negedge CLOCK_50);
      chk("lat_before", {28'd0, DIGITS[11:8]}, 32'hF);
      @(negedge CLOCK_50);
      chk("lat_at5", {28'd0, DIGITS[11:8]}, 32'h2);
      chk("lat_upd", {31'd0, UPDATE}, 32'h1);
      chk("lat_blank2", {31'd0, BLANK[2]}, 32'h0);
      repeat (4) @(negedge CLOCK_50);

      // Scan 7,3,9,0 over slots 0..3, twice.
      push(K_UPD, 16'hF2F7, 4'b1010, 4'b0000);
      push(K_UPD, 16'hF237, 4'b1000, 4'b0000);
      push(K_UPD, 16'hF937, 4'b1000, 4'b0000);
      push(K_UPD, 16'h0937, 4'b0000, 4'b0000);
      for (int p = 0; p < 2; p++) begin
         apply(7'b0001111, 4'b0001, 8);
         apply(7'b0000110, 4'b0010, 8);
         apply(7'b0000100, 4'b0100, 8);
         apply(7'b0000001, 4'b1000, 8);
         if (p == 0) chk("scan_q_empty", sbq.size(), 0);
      end
      chk("scan_digits", {16'd0, DIGITS}, 32'h0937);

      // Short run of 3 samples must not write.
      apply(7'b0010010, 4'b1000, 3);
      apply(7'b0000001, 4'b1000, 8);
      chk("short_digits", {16'd0, DIGITS}, 32'h0937);

      // Undecodable pattern into slot 0, then multi-hot select.
      push(K_UPD, 16'h093E, 4'b0000, 4'b0001);
      apply(7'b1110110, 4'b0001, 6);
      @(negedge CLOCK_50);
      chk("bad_err0", {31'd0, ERR[0]}, 32'h1);
      push(K_SEL, 16'h093E, 4'b0000, 4'b0001);
      apply(7'b1110110, 4'b0011, 6);
      @(negedge CLOCK_50);
      chk("selerr_digits", {16'd0, DIGITS}, 32'h093E);

      // Slot 1 = 5, then reset in the middle of a new run.
      push(K_UPD, 16'h095E, 4'b0000, 4'b0001);
      apply(7'b0100100, 4'b0010, 8);
      chk("s1_digits", {16'd0, DIGITS}, 32'h095E);
      apply(7'b0100000, 4'b0010, 2);
      RESET_N = 1'b0;
      #1;
      chk("mid_rst_digits", {16'd0, DIGITS}, 32'hFFFF);
      chk("mid_rst_blank", {28'd0, BLANK}, 32'hF);
      chk("mid_rst_err", {28'd0, ERR}, 32'h0);
      repeat (2) @(negedge CLOCK_50);
      push(K_UPD, 16'hFF6F, 4'b1101, 4'b0000);
      RESET_N = 1'b1;
      repeat (5) @(negedge CLOCK_50);
      chk("post_rst_before", {28'd0, DIGITS[7:4]}, 32'hF);
      @(negedge CLOCK_50);
      chk("post_rst_at5", {28'd0, DIGITS[7:4]}, 32'h6);
      repeat (6) @(negedge CLOCK_50);
      chk("final_q_empty", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
